// File: rtl/gpu_pkg.sv
// Shared screen geometry, command encodings and helpers for the pixel writer
// and gpu_core.
package gpu_pkg;

  localparam int GPU_COLS           = 40;
  localparam int GPU_ROWS           = 30;
  localparam int GPU_CELLS_PER_WORD = 4;
  localparam int GPU_WORDS_PER_ROW  = 10;
  localparam int GPU_WORDS          = 300;

  localparam logic OP_SET = 1'b0;
  localparam logic OP_CLR = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    CLR  = 3'd3,
    FIN  = 3'd4
  } wr_state_t;

  typedef logic [3:0] colour_t;

  // Cell 0 of a word sits in the most significant nibble.
  function automatic logic [15:0] nib_merge(input logic [15:0] word,
                                            input logic [1:0]  nib,
                                            input colour_t     c);
    logic [15:0] r;
    r = word;
    case (nib)
      2'd0:    r[15:12] = c;
      2'd1:    r[11:8]  = c;
      2'd2:    r[7:4]   = c;
      2'd3:    r[3:0]   = c;
      default: r        = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpu_pixel_writer_if.sv
// Command handshake plus the CPU-side RAM port of gpu_core, bundled for the
// pixel writer. "slave" is the writer's view, "master" the environment's.
interface gpu_pixel_writer_if;

  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_OP;
  logic [5:0]  CMD_X;
  logic [4:0]  CMD_Y;
  logic [3:0]  CMD_COLOR;
  logic        DONE;
  logic        ERR;
  logic [8:0]  ADDR;
  logic [15:0] DATA;
  logic        WREN;
  logic [15:0] Q;

  modport master (
    output CMD_VALID, CMD_OP, CMD_X, CMD_Y, CMD_COLOR, Q,
    input  CMD_READY, DONE, ERR, ADDR, DATA, WREN
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_X, CMD_Y, CMD_COLOR, Q,
    output CMD_READY, DONE, ERR, ADDR, DATA, WREN
  );

endinterface

// File: rtl/gpu_pixel_addr.sv
// Cell coordinate to word address / nibble mapping with a range flag.
// Purely combinational so gpu_core can reuse it on its read side.
module gpu_pixel_addr
  import gpu_pkg::*;
#(
  parameter int COLS = GPU_COLS,
  parameter int ROWS = GPU_ROWS
) (
  input  logic [5:0] i_x,
  input  logic [4:0] i_y,
  output logic [8:0] o_addr,
  output logic [1:0] o_nib,
  output logic       o_in_range
);

  logic [8:0] w_row_base;

  // y*10 peaks at 310 for a 5-bit row, so 9 bits never wrap.
  assign w_row_base = {4'b0000, i_y} * 9'(GPU_WORDS_PER_ROW);
  assign o_addr     = w_row_base + {5'b00000, i_x[5:2]};
  assign o_nib      = i_x[1:0];
  assign o_in_range = (i_x < 6'(COLS)) && (i_y < 5'(ROWS));

endmodule

// File: rtl/gpu_pixel_writer.sv
// Command-driven pixel writer: read-modify-write of single cells and a
// full-screen clear, driving gpu_core's CPU-side RAM port.
module gpu_pixel_writer
  import gpu_pkg::*;
#(
  parameter int COLS   = GPU_COLS,
  parameter int ROWS   = GPU_ROWS,
  parameter int RD_LAT = 1
) (
  input logic               CLK,
  input logic               RST,
  gpu_pixel_writer_if.slave bus
);

  localparam logic [8:0] LAST_WORD   = 9'(COLS * ROWS / GPU_CELLS_PER_WORD - 1);
  localparam logic [1:0] RD_CNT_INIT = 2'(RD_LAT - 1);

  wr_state_t   r_state;
  logic [1:0]  r_cnt;
  logic [1:0]  r_nib;
  colour_t     r_color;
  logic        r_ready;
  logic        r_done;
  logic        r_err;
  logic [8:0]  r_addr;
  logic [15:0] r_data;
  logic        r_wren;

  logic [8:0]  w_addr;
  logic [1:0]  w_nib;
  logic        w_in_range;
  logic        w_accept;

  gpu_pixel_addr #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_addr (
    .i_x        (bus.CMD_X),
    .i_y        (bus.CMD_Y),
    .o_addr     (w_addr),
    .o_nib      (w_nib),
    .o_in_range (w_in_range)
  );

  assign w_accept = bus.CMD_VALID && r_ready;

  // Command FSM; every RAM and handshake output is a register of this block.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_nib   <= 2'd0;
      r_color <= 4'd0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 9'd0;
      r_data  <= 16'd0;
      r_wren  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_color <= bus.CMD_COLOR;
            if (bus.CMD_OP == OP_CLR) begin
              r_state <= CLR;
              r_addr  <= 9'd0;
              r_data  <= {4{bus.CMD_COLOR}};
              r_wren  <= 1'b1;
            end else if (w_in_range) begin
              r_state <= RD;
              r_addr  <= w_addr;
              r_nib   <= w_nib;
              r_cnt   <= RD_CNT_INIT;
              r_wren  <= 1'b0;
            end else begin
              r_state <= FIN;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        RD: begin
          // ADDR is held steady until the RAM's read latency has elapsed.
          if (r_cnt == 2'd0) begin
            r_data  <= nib_merge(bus.Q, r_nib, r_color);
            r_wren  <= 1'b1;
            r_state <= WR;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        WR: begin
          r_wren  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= FIN;
        end
        CLR: begin
          if (r_addr == LAST_WORD) begin
            r_wren  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_addr <= r_addr + 9'd1;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_wren  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.CMD_READY = r_ready;
  assign bus.DONE      = r_done;
  assign bus.ERR       = r_err;
  assign bus.ADDR      = r_addr;
  assign bus.DATA      = r_data;
  assign bus.WREN      = r_wren;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Self-checking bench for gpu_pixel_writer: a RAM model plus a per-command
// expected-output schedule, compared on every falling edge.
module tb_gpu_pixel_writer;
  import gpu_pkg::*;

  localparam int RD_LAT = 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  gpu_pixel_writer_if bus();

  gpu_pixel_writer #(
    .COLS   (40),
    .ROWS   (30),
    .RD_LAT (RD_LAT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ready;
    logic        wren;
    logic        done;
    logic        err;
    logic        chk_addr;
    logic        chk_data;
    logic [8:0]  addr;
    logic [15:0] data;
  } snap_t;

  bit [15:0]   ram  [300];
  bit [15:0]   gold [300];
  bit [15:0]   pre  [300];
  snap_t       exp_q[$];
  snap_t       cur = '0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        pl_en  = 1'b0;
  logic [8:0]  pl_addr = 9'd0;
  logic [15:0] pl_data = 16'd0;
  logic        resync = 1'b0;

  assign bus.Q = (bus.ADDR < 9'd300) ? ram[bus.ADDR] : 16'h0000;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic snap_t mk(input logic rdy, input logic wr, input logic dn,
                               input logic er, input logic ca, input logic cd,
                               input logic [8:0] a, input logic [15:0] d);
    snap_t s;
    s.ready = rdy; s.wren = wr; s.done = dn; s.err = er;
    s.chk_addr = ca; s.chk_data = cd; s.addr = a; s.data = d;
    return s;
  endfunction

  // Expected output schedule for one accepted command, from the screen rules.
  task automatic model_accept(input logic op, input int x, input int y, input logic [3:0] c);
    logic [15:0] fill, cw, d;
    int a, sh;
    if (op == OP_CLR) begin
      fill = {4{c}};
      for (int k = 0; k < 300; k++) begin
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'(k), fill));
        gold[k] = fill;
      end
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0));
    end else if (x >= 40 || y >= 30) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 16'd0));
    end else begin
      a  = y * 10 + x / 4;
      sh = 12 - 4 * (x % 4);
      cw = 16'(c);
      d  = (gold[a] & ~(16'h000F << sh)) | (cw << sh);
      gold[a] = d;
      for (int k = 0; k < RD_LAT; k++)
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'(a), 16'd0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'(a), d));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0));
    end
  endtask

  // RAM model and reference schedule advance on the rising edge.
  always @(posedge CLK) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
      gold[pl_addr] = pl_data;
    end else if (bus.WREN && bus.ADDR < 9'd300) begin
      ram[bus.ADDR] <= bus.DATA;
    end
    if (resync) gold = ram;
    if (RST) begin
      exp_q.delete();
      cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, 16'd0);
    end else begin
      if (cur.ready && bus.CMD_VALID)
        model_accept(bus.CMD_OP, int'(bus.CMD_X), int'(bus.CMD_Y), bus.CMD_COLOR);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0);
    end
  end

  // Per-cycle comparison against the schedule, away from the active edge.
  always @(negedge CLK) begin
    check("cmd_ready", int'(bus.CMD_READY), int'(cur.ready));
    check("wren", int'(bus.WREN), int'(cur.wren));
    check("done", int'(bus.DONE), int'(cur.done));
    check("err", int'(bus.ERR), int'(cur.err));
    if (cur.chk_addr) check("addr", int'(bus.ADDR), int'(cur.addr));
    if (cur.chk_data) check("data", int'(bus.DATA), int'(cur.data));
  end

  task automatic preload(input int a, input logic [15:0] d);
    @(negedge CLK);
    pl_en = 1'b1; pl_addr = 9'(a); pl_data = d;
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  // Present a command and return just after the edge that accepts it.
  task automatic send(input logic op, input int x, input int y, input logic [3:0] c,
                      input bit keep);
    bit ok;
    ok = 1'b0;
    @(negedge CLK);
    bus.CMD_OP = op; bus.CMD_X = 6'(x); bus.CMD_Y = 5'(y); bus.CMD_COLOR = c;
    bus.CMD_VALID = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (bus.CMD_READY) begin
        @(posedge CLK);
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!ok) check("accept_timeout", 0, 1);
    if (!keep) begin
      #1 bus.CMD_VALID = 1'b0;
    end
  endtask

  task automatic watch_wr(output int lat, output int a, output int d);
    lat = -1; a = 0; d = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge CLK);
      if (bus.WREN) begin
        lat = k; a = int'(bus.ADDR); d = int'(bus.DATA);
        break;
      end
    end
    if (lat < 0) check("wren_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge CLK);
    check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int lat, a, d, n, bad;
    bus.CMD_VALID = 1'b0; bus.CMD_OP = 1'b0; bus.CMD_X = 6'd0;
    bus.CMD_Y = 5'd0; bus.CMD_COLOR = 4'd0;

    // Reset state and preloads used by the directed cases.
    repeat (2) @(negedge CLK);
    check("rst_ready", int'(bus.CMD_READY), 0);
    check("rst_wren", int'(bus.WREN), 0);
    preload(21, 16'h1234);
    preload(299, 16'hAAAA);
    preload(290, 16'hAAAA);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", int'(bus.CMD_READY), 1);

    // Pixel (5,2) colour F over 0x1234.
    send(OP_SET, 5, 2, 4'hF, 1'b0);
    watch_wr(lat, a, d);
    check("t1_latency", lat, RD_LAT + 1);
    check("t1_addr", a, 21);
    check("t1_data", d, 16'h1F34);
    @(negedge CLK);
    check("t1_done", int'(bus.DONE), 1);
    @(negedge CLK);
    check("t1_ready", int'(bus.CMD_READY), 1);

    // Corner cells.
    send(OP_SET, 39, 29, 4'h7, 1'b0);
    watch_wr(lat, a, d);
    check("t2_addr_299", a, 299);
    check("t2_data_aaa7", d, 16'hAAA7);
    drain();
    send(OP_SET, 0, 29, 4'h7, 1'b0);
    watch_wr(lat, a, d);
    check("t2_addr_290", a, 290);
    check("t2_data_7aaa", d, 16'h7AAA);
    drain();

    // Out-of-range set-pixel commands.
    send(OP_SET, 40, 5, 4'h3, 1'b0);
    @(negedge CLK);
    check("t3_err", int'(bus.ERR), 1);
    check("t3_done", int'(bus.DONE), 1);
    @(negedge CLK);
    check("t3_ready", int'(bus.CMD_READY), 1);
    send(OP_SET, 3, 30, 4'h3, 1'b0);
    drain();

    // Clear with 0xF; coordinates are ignored.
    send(OP_CLR, 63, 31, 4'hF, 1'b0);
    n = 0; bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (bus.DONE) break;
      if (bus.WREN) begin
        if (int'(bus.ADDR) != n || bus.DATA != 16'hFFFF) bad++;
        n++;
      end
    end
    check("t4_wren_cycles", n, 300);
    check("t4_bad_words", bad, 0);
    drain();

    // Back-to-back set-pixels into one word with CMD_VALID held.
    send(OP_SET, 0, 0, 4'h1, 1'b1);
    send(OP_SET, 1, 0, 4'h2, 1'b1);
    send(OP_SET, 2, 0, 4'h3, 1'b0);
    drain();
    check("t5_word0", int'(ram[0]), 16'h123F);

    // Asynchronous reset during the 100th clear write.
    pre = ram;
    send(OP_CLR, 0, 0, 4'h5, 1'b0);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (bus.WREN && bus.ADDR == 9'd99) begin
        n = 1;
        break;
      end
    end
    check("t6_reach_99", n, 1);
    #2 RST = 1'b1;
    #1;
    check("t6_async_wren", int'(bus.WREN), 0);
    check("t6_no_done", int'(bus.DONE), 0);
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("t6_ready", int'(bus.CMD_READY), 1);
    bad = 0;
    for (int w = 0; w < 300; w++) begin
      if (w < 99 && ram[w] != 16'h5555) bad++;
      if (w == 99 && ram[w] != 16'h5555 && ram[w] != pre[w]) bad++;
      if (w > 99 && ram[w] != pre[w]) bad++;
    end
    check("t6_words", bad, 0);
    @(negedge CLK);
    resync = 1'b1;
    @(negedge CLK);
    resync = 1'b0;

    // Random command stream against the reference picture.
    for (int i = 0; i < 40; i++) begin
      send(($urandom_range(0, 15) == 0) ? OP_CLR : OP_SET,
           int'($urandom_range(0, 45)), int'($urandom_range(0, 31)),
           4'($urandom_range(0, 15)), (i != 39) && ($urandom_range(0, 1) == 1));
    end
    drain();
    bad = 0;
    for (int w = 0; w < 300; w++) if (ram[w] != gold[w]) bad++;
    check("ram_vs_model", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
